aes_round_stage: RTL
====================

AES_ROUND_STAGE -- requirements
Module: aes_round_stage

Interface
REQ-001 SHALL have parameter NUM_LANES, default 3, meaning the number of independent 128-bit state lanes (H, J0, CB).
REQ-002 SHALL have parameter NR, default 10, meaning total AES rounds (10/12/14); the key schedule width is KS_W = (NR+1)*128.
REQ-003 SHALL have parameter RPS, default 1, meaning rounds applied per lane per stage (1..NR+1).
REQ-004 SHALL have parameter SB_W, default 387, meaning the width of the sideband carried unmodified (phase, plain text, aad, instance size).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 i_valid  in  1  input beat valid.
REQ-008 o_ready  out  1  stage can accept a beat.
REQ-009 i_state  in  NUM_LANES*128  per-lane AES state, lane 0 in the MSBs.
REQ-010 i_round  in  NUM_LANES*4  per-lane index of the first round to apply.
REQ-011 i_lane_en  in  NUM_LANES  1 = apply rounds to the lane; 0 = pass the lane through unchanged.
REQ-012 i_key_schedule  in  KS_W  round keys, key[0] in the MSBs.
REQ-013 i_sideband  in  SB_W  opaque data carried with the beat.
REQ-014 o_valid  out  1  output beat valid.
REQ-015 i_ready  in  1  downstream accepts the beat.
REQ-016 o_state / o_round / o_key_schedule / o_sideband  out  same widths as the matching inputs  result state, next round index, carried key schedule, carried sideband.
REQ-017 o_round_err  out  NUM_LANES  per lane: an enabled lane's round index exceeded NR.

Function
REQ-018 A beat SHALL transfer on the input when i_valid&&o_ready, and on the output when o_valid&&i_ready.
REQ-019 The stage SHALL register the beat (state, round, enable, key schedule, sideband) and compute the rounds combinationally from the registers; latency is 1 cycle from input transfer to o_valid.
REQ-020 A 2-entry skid buffer SHALL be used: o_ready = !skid_full, driven from a register only; throughput SHALL be 1 beat/cycle while i_ready=1.
REQ-021 On a stall (o_valid&&!i_ready), the o_* outputs SHALL hold stable, and one further accepted beat SHALL go to the skid entry; o_ready SHALL then drop on the next cycle.
REQ-022 On a simultaneous output transfer and input accept, beat order SHALL be preserved (skid drains first) and no beat SHALL be lost or duplicated.
REQ-023 For each enabled lane, rounds r = i_round .. i_round+RPS-1 SHALL apply in order; rounds with r > NR SHALL not be applied.
REQ-024 Round 0 SHALL be AddRoundKey(key[0]) only.
REQ-025 Rounds 1..NR-1 SHALL be SubBytes, ShiftRows, MixColumns, AddRoundKey(key[r]).
REQ-026 Round NR SHALL omit MixColumns.
REQ-027 For each lane, o_round SHALL be min(i_round+RPS, NR+1) when the lane is enabled, else i_round unchanged; it uses 4-bit arithmetic with no wrap past NR+1.
REQ-028 o_round_err[l] SHALL be 1 if an enabled lane has i_round > NR; that lane's state SHALL pass through unchanged.
REQ-029 Disabled lanes, o_key_schedule and o_sideband SHALL equal their registered inputs bit-exactly.

Reset
REQ-030 While rst_n=0: o_valid=0, skid empty, o_ready=0, and all data registers = 0, so o_state, o_round and o_round_err read 0.
REQ-031 o_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight and skid beats with no partial output.

Verification
REQ-033 Bench SHALL cover: NR=10, RPS=2; state 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, i_round=0 -> o_state 89d810e8855ace682d1843d8cb128fe4, o_round=2, one cycle later.
REQ-034 Bench SHALL cover: 11 cascaded RPS=1 stages on the same vector -> 69c4e0d86a7b0430d8cdb78070b4c55a, o_round=11.
REQ-035 Bench SHALL cover: i_lane_en=3'b010, sideband random -> lanes 0 and 2 state and round bit-exact, sideband bit-exact.
REQ-036 Bench SHALL cover: i_round=12, NR=10 -> o_round_err lane bit=1, state unchanged.
REQ-037 Bench SHALL cover: 8 back-to-back beats with i_ready toggled randomly -> all 8 outputs in order, no duplicates, o_ready low only while the skid is full.
REQ-038 Bench SHALL cover: rst_n pulsed low with the skid full -> o_valid=0 immediately, no stale beat after release.

Source files
------------

// File: rtl/aes_round_stage.sv
// ---------------------------------------------------------------------------
// aes_round_stage
//   One pipeline stage of an iterative multi-lane AES encryptor. Each beat
//   carries NUM_LANES independent 128-bit states (H, J0, CB), a per-lane
//   round index, the full key schedule and an opaque sideband. The beat is
//   registered, and up to RPS AES rounds per enabled lane are computed
//   combinationally from that register. A second register (the skid entry)
//   absorbs one extra beat when the output stalls.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   i_valid/o_ready  input handshake (o_ready comes straight from a flop)
//   i_state          per-lane state, lane 0 in the MSBs
//   i_round          per-lane first round index (4 bits), lane 0 in the MSBs
//   i_lane_en        bit l enables rounds on lane l
//   i_key_schedule   round keys, key[0] in the MSBs
//   i_sideband       carried unmodified
//   o_valid/i_ready  output handshake
//   o_state/o_round  result state and next round index per lane
//   o_key_schedule   carried key schedule
//   o_sideband       carried sideband
//   o_round_err      bit l: lane l was enabled with a round index above NR
// ---------------------------------------------------------------------------
module aes_round_stage #(
    parameter int  NUM_LANES = 3,
    parameter int  NR        = 10,
    parameter int  RPS       = 1,
    parameter int  SB_W      = 387,
    localparam int KS_W      = (NR + 1) * 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [NUM_LANES*128-1:0] i_state,
    input  logic [NUM_LANES*4-1:0]   i_round,
    input  logic [NUM_LANES-1:0]     i_lane_en,
    input  logic [KS_W-1:0]          i_key_schedule,
    input  logic [SB_W-1:0]          i_sideband,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [NUM_LANES*128-1:0] o_state,
    output logic [NUM_LANES*4-1:0]   o_round,
    output logic [KS_W-1:0]          o_key_schedule,
    output logic [SB_W-1:0]          o_sideband,
    output logic [NUM_LANES-1:0]     o_round_err
);

    typedef struct packed {
        logic [NUM_LANES*128-1:0] state;
        logic [NUM_LANES*4-1:0]   round;
        logic [NUM_LANES-1:0]     lane_en;
        logic [KS_W-1:0]          ks;
        logic [SB_W-1:0]          sb;
    } beat_t;

    // ---------------- GF(2^8) / AES primitives ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (a^254, so 0 maps to 0) plus the
    // affine transform; avoids carrying a 256-entry table per byte.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Byte i of the state is s[127-8i -: 8]; AES row r, column c is byte 4c+r.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic first, input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        if (first) return s ^ k;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = b[4*((c+r)%4)+r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c];   a1 = t[4*c+1];
                a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] round_key(input logic [KS_W-1:0] ks, input int r);
        return ks[KS_W-1-128*r -: 128];
    endfunction

    // ---------------- skid buffer ----------------
    beat_t main_q, main_d, skid_q, skid_d, in_beat;
    logic  main_valid_q, main_valid_d;
    logic  skid_valid_q, skid_valid_d;
    logic  ready_q, ready_d;
    logic  in_fire, out_fire;

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        in_beat.state   = i_state;
        in_beat.round   = i_round;
        in_beat.lane_en = i_lane_en;
        in_beat.ks      = i_key_schedule;
        in_beat.sb      = i_sideband;

        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        in_fire  = i_valid && ready_q;
        out_fire = main_valid_q && i_ready;

        // ready_q is low whenever the skid is full, so an input accept and a
        // skid drain never coincide: the skid always drains into main first.
        if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_fire;
                if (in_fire) main_d = in_beat;
            end
        end else if (in_fire) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end

        ready_d = !skid_valid_d;
    end

    // NOTE: state registers use non-blocking assignments so all flops sample
    // the pre-edge values; the comb block above uses blocking assignments.
    // NOTE: the wide data registers are reset as well, so o_state, o_round
    // and o_round_err read 0 during reset and no stale beat survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    // ---------------- round datapath ----------------
    always_comb begin : round_datapath
        logic [127:0] st;
        logic [3:0]   rnd;
        logic         en;
        logic         err;
        int           r;
        int           nxt;
        st = '0; rnd = '0; en = 1'b0; err = 1'b0; r = 0; nxt = 0;
        o_state     = '0;
        o_round     = '0;
        o_round_err = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            st  = main_q.state[NUM_LANES*128-1-128*l -: 128];
            rnd = main_q.round[NUM_LANES*4-1-4*l -: 4];
            en  = main_q.lane_en[l];
            err = en && (int'(rnd) > NR);
            if (en && !err) begin
                for (int k = 0; k < RPS; k++) begin
                    r = int'(rnd) + k;
                    if (r <= NR) st = aes_round(st, round_key(main_q.ks, r), r == 0, r == NR);
                end
            end
            // Saturate at NR+1 ("done") instead of letting the 4-bit index wrap.
            nxt = int'(rnd) + RPS;
            if (nxt > NR + 1) nxt = NR + 1;
            o_state[NUM_LANES*128-1-128*l -: 128] = st;
            o_round[NUM_LANES*4-1-4*l -: 4]       = en ? 4'(nxt) : rnd;
            o_round_err[l]                        = err;
        end
    end

    assign o_valid        = main_valid_q;
    assign o_ready        = ready_q;
    assign o_key_schedule = main_q.ks;
    assign o_sideband     = main_q.sb;

endmodule
